// File: rtl/qs_srt_ucode_seq.sv
// Microcode sequencer for the quicksort engine: executes control-flow opcodes
// locally, issues datapath opcodes, and tracks flag/BLINK hazards.
module qs_srt_ucode_seq #(
    parameter int PC_W      = 8,
    parameter int INST_W    = 16,
    parameter int BLINK_IDX = 7
) (
    input  logic              clk,
    input  logic              rst,
    output logic [PC_W-1:0]   ra,
    input  logic [INST_W-1:0] rout,
    output logic              issue_vld,
    output logic [INST_W-1:0] issue_inst,
    input  logic              issue_rdy,
    input  logic              flags_vld,
    input  logic              flags_eq,
    input  logic              flags_gt,
    input  logic              blink_wr_en,
    input  logic [PC_W-1:0]   blink_wr_data,
    output logic [PC_W-1:0]   blink_rd,
    input  logic              dp_idle,
    input  logic              bank_in_vld,
    output logic              bank_in_ack,
    output logic              bank_out_vld,
    input  logic              bank_out_rdy,
    output logic              err
);

    typedef enum logic {RUN = 1'b0, ERR = 1'b1} state_t;

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_JCC  = 4'h1;
    localparam logic [3:0] OP_STK  = 4'h2;
    localparam logic [3:0] OP_MEM  = 4'h4;
    localparam logic [3:0] OP_MOV  = 4'h6;
    localparam logic [3:0] OP_ALU  = 4'h7;
    localparam logic [3:0] OP_CALL = 4'hC;
    localparam logic [3:0] OP_BANK = 4'hF;

    localparam logic [2:0]      BLINK_R = 3'(BLINK_IDX);
    localparam logic [PC_W-1:0] PC_ONE  = {{(PC_W-1){1'b0}}, 1'b1};

    state_t          state, state_nxt;
    logic [PC_W-1:0] pc, pc_nxt, pc_inc, blink, target, ret_addr;
    logic            flag_eq, flag_gt, flags_pend, blink_pend;
    logic [3:0]      opc;
    logic            sub_op;
    logic [2:0]      rrr;
    logic [1:0]      cc;
    logic            is_sub, wr_blink, issue_fire, call_fire, running, jcc_taken;

    assign opc      = rout[15:12];
    assign sub_op   = rout[11];
    assign rrr      = rout[10:8];
    assign cc       = rout[9:8];
    assign target   = rout[PC_W-1:0];
    assign pc_inc   = pc + PC_ONE;
    assign is_sub   = (opc == OP_ALU) && sub_op;
    assign wr_blink = ((opc == OP_STK && sub_op) || opc == OP_MOV) && (rrr == BLINK_R);
    assign running  = (state == RUN) && !rst;
    // A BLINK write landing in the same cycle a stalled RET releases must win.
    assign ret_addr = blink_wr_en ? blink_wr_data : blink;

    always_comb begin
        jcc_taken = 1'b0;
        case (cc)
            2'b00:   jcc_taken = 1'b1;
            2'b01:   jcc_taken = flag_eq;
            2'b10:   jcc_taken = flag_gt;
            default: jcc_taken = !flag_gt;
        endcase
    end

    // Handshakes (issue_vld/issue_rdy, bank_out_vld/bank_out_rdy): a transfer
    // happens on a cycle where both are high; while valid is high and ready is
    // low, the PC and therefore the payload are held unchanged.
    always_comb begin
        state_nxt    = state;
        pc_nxt       = pc;
        issue_vld    = 1'b0;
        bank_in_ack  = 1'b0;
        bank_out_vld = 1'b0;
        call_fire    = 1'b0;
        if (running) begin
            case (opc)
                OP_NOP: pc_nxt = pc_inc;
                OP_JCC: begin
                    if (cc == 2'b00 && target == pc)
                        state_nxt = ERR;
                    else if (cc == 2'b00 || !flags_pend)
                        pc_nxt = jcc_taken ? target : pc_inc;
                end
                OP_STK, OP_MEM, OP_MOV, OP_ALU: begin
                    if (!(is_sub && flags_pend)) begin
                        issue_vld = 1'b1;
                        if (issue_rdy)
                            pc_nxt = pc_inc;
                    end
                end
                OP_CALL: begin
                    if (!sub_op) begin
                        if (!blink_pend) begin
                            call_fire = 1'b1;
                            pc_nxt    = target;
                        end
                    end else if (!blink_pend || blink_wr_en) begin
                        pc_nxt = ret_addr;
                    end
                end
                OP_BANK: begin
                    if (!sub_op) begin
                        if (bank_in_vld && dp_idle) begin
                            bank_in_ack = 1'b1;
                            pc_nxt      = pc_inc;
                        end
                    end else if (dp_idle && !flags_pend && !blink_pend) begin
                        bank_out_vld = 1'b1;
                        if (bank_out_rdy)
                            pc_nxt = pc_inc;
                    end
                end
                default: state_nxt = ERR;
            endcase
        end
    end

    assign issue_fire = issue_vld && issue_rdy;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RUN;
            pc         <= '0;
            blink      <= '0;
            flag_eq    <= 1'b0;
            flag_gt    <= 1'b0;
            flags_pend <= 1'b0;
            blink_pend <= 1'b0;
        end else begin
            state <= state_nxt;
            pc    <= pc_nxt;
            if (call_fire)
                blink <= pc_inc;
            else if (blink_wr_en)
                blink <= blink_wr_data;
            // A new flag op issuing alongside the old op's flags keeps pend set.
            if (issue_fire && is_sub)
                flags_pend <= 1'b1;
            else if (flags_vld)
                flags_pend <= 1'b0;
            if (flags_vld) begin
                flag_eq <= flags_eq;
                flag_gt <= flags_gt;
            end
            if (issue_fire && wr_blink)
                blink_pend <= 1'b1;
            else if (blink_wr_en)
                blink_pend <= 1'b0;
        end
    end

    assign ra         = pc;
    assign issue_inst = rst ? '0 : rout;
    assign blink_rd   = rst ? '0 : blink;
    assign err        = !rst && (state == ERR);

endmodule

// File: tb/tb_qs_srt_ucode_seq.sv
// Bench for qs_srt_ucode_seq: vector table, directed multi-cycle sequences and
// random programs compared against an instruction-level model.
module tb_qs_srt_ucode_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  ra;
    logic [15:0] rout;
    logic        issue_vld;
    logic [15:0] issue_inst;
    logic        issue_rdy, flags_vld, flags_eq, flags_gt, blink_wr_en;
    logic [7:0]  blink_wr_data, blink_rd;
    logic        dp_idle, bank_in_vld, bank_in_ack, bank_out_vld, bank_out_rdy, err;

    logic [15:0] rom [256];
    assign rout = rom[ra];

    always #5 clk = ~clk;

    qs_srt_ucode_seq dut (
        .clk(clk), .rst(rst), .ra(ra), .rout(rout),
        .issue_vld(issue_vld), .issue_inst(issue_inst), .issue_rdy(issue_rdy),
        .flags_vld(flags_vld), .flags_eq(flags_eq), .flags_gt(flags_gt),
        .blink_wr_en(blink_wr_en), .blink_wr_data(blink_wr_data), .blink_rd(blink_rd),
        .dp_idle(dp_idle), .bank_in_vld(bank_in_vld), .bank_in_ack(bank_in_ack),
        .bank_out_vld(bank_out_vld), .bank_out_rdy(bank_out_rdy), .err(err)
    );

    int n_chk  = 0;
    int n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        issue_rdy = 1'b1; flags_vld = 1'b0; flags_eq = 1'b0; flags_gt = 1'b0;
        blink_wr_en = 1'b0; blink_wr_data = 8'h00; dp_idle = 1'b1;
        bank_in_vld = 1'b0; bank_out_rdy = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    function automatic logic [15:0] j_op(input logic [1:0] c, input logic [7:0] t);
        return {4'h1, 2'b00, c, t};
    endfunction

    function automatic logic [15:0] call_op(input logic [7:0] t);
        return {4'hC, 4'h0, t};
    endfunction

    // ---------------- vector table ----------------
    typedef struct {
        logic [15:0] inst;
        logic [4:0]  ins;     // issue_rdy, dp_idle, bank_in_vld, bank_out_rdy, blink_wr_en
        logic [7:0]  wd;
        logic [2:0]  eo;      // issue_vld, bank_in_ack, bank_out_vld
        logic [7:0]  era;
        logic        eerr;
        logic [7:0]  eblink;
    } vec_t;
    vec_t vecs[$];

    function automatic void add_vec(input logic [15:0] inst, input logic [4:0] ins,
                                    input logic [7:0] wd, input logic [2:0] eo,
                                    input logic [7:0] era, input logic eerr,
                                    input logic [7:0] eblink);
        vec_t v;
        v.inst = inst; v.ins = ins; v.wd = wd; v.eo = eo;
        v.era = era; v.eerr = eerr; v.eblink = eblink;
        vecs.push_back(v);
    endfunction

    // ---------------- reference model ----------------
    int m_pc, m_blink;
    bit m_eq, m_gt, m_fp, m_bp, m_err;

    task automatic model_reset();
        m_pc = 0; m_blink = 0; m_eq = 0; m_gt = 0; m_fp = 0; m_bp = 0; m_err = 0;
    endtask

    function automatic bit cond_holds(input int c);
        if (c == 1) return m_eq;
        if (c == 2) return m_gt;
        if (c == 3) return !m_gt;
        return 1'b1;
    endfunction

    // One instruction-level step: returns expected handshake outputs, advances state.
    task automatic model_step(output bit e_iss, output bit e_ack, output bit e_outv);
        logic [15:0] ins;
        int  op, tgt, cc, next_pc, seq_pc, new_blink;
        bit  alt, blink_dest, issued, called, new_err;
        ins        = rom[m_pc[7:0]];
        op         = int'(ins[15:12]);
        alt        = ins[11];
        tgt        = int'(ins[7:0]);
        cc         = int'(ins[9:8]);
        blink_dest = ((op == 2 && alt) || op == 6) && (ins[10:8] == 3'd7);
        seq_pc     = (m_pc + 1) % 256;
        next_pc    = m_pc;
        new_err    = m_err;
        new_blink  = m_blink;
        issued = 0; called = 0; e_iss = 0; e_ack = 0; e_outv = 0;
        if (!m_err) begin
            if (op == 0) begin
                next_pc = seq_pc;
            end else if (op == 1) begin
                if (cc == 0 && tgt == m_pc) new_err = 1;
                else if (cc == 0 || !m_fp) next_pc = cond_holds(cc) ? tgt : seq_pc;
            end else if (op == 2 || op == 4 || op == 6 || op == 7) begin
                e_iss = !(op == 7 && alt && m_fp);
                issued = e_iss && issue_rdy;
                if (issued) next_pc = seq_pc;
            end else if (op == 12 && !alt) begin
                if (!m_bp) begin called = 1; next_pc = tgt; end
            end else if (op == 12) begin
                if (blink_wr_en) next_pc = int'(blink_wr_data);
                else if (!m_bp) next_pc = m_blink;
            end else if (op == 15 && !alt) begin
                e_ack = bank_in_vld && dp_idle;
                if (e_ack) next_pc = seq_pc;
            end else if (op == 15) begin
                e_outv = dp_idle && !m_fp && !m_bp;
                if (e_outv && bank_out_rdy) next_pc = seq_pc;
            end else begin
                new_err = 1;
            end
        end
        if (called) new_blink = seq_pc;
        else if (blink_wr_en) new_blink = int'(blink_wr_data);
        if (flags_vld) begin m_eq = flags_eq; m_gt = flags_gt; end
        if (issued && op == 7 && alt) m_fp = 1;
        else if (flags_vld) m_fp = 0;
        if (issued && blink_dest) m_bp = 1;
        else if (blink_wr_en) m_bp = 0;
        m_blink = new_blink;
        m_pc    = next_pc;
        m_err   = new_err;
    endtask

    function automatic logic [15:0] rand_inst();
        int          r;
        logic [15:0] lo;
        logic [3:0]  op;
        r  = $urandom_range(0, 99);
        lo = 16'($urandom);
        if (r < 8) return 16'h0000;
        if (r < 24) return {4'h1, lo[11:0]};
        if (r < 44) begin
            case (r % 4)
                0:       op = 4'h2;
                1:       op = 4'h4;
                2:       op = 4'h6;
                default: op = 4'h7;
            endcase
            if (lo[15]) lo[10:8] = 3'd7;
            return {op, lo[11:0]};
        end
        if (r < 52) return {4'hC, 1'b0, lo[10:0]};
        if (r < 60) return {4'hC, 1'b1, lo[10:0]};
        if (r < 70) return {4'hF, 1'b0, lo[10:0]};
        if (r < 78) return {4'hF, 1'b1, lo[10:0]};
        if (r < 80) return (r == 78) ? {4'h3, lo[11:0]} : {4'hA, lo[11:0]};
        return {4'h7, 1'b1, lo[10:0]};
    endfunction

    initial begin
        #1000000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        vec_t v;
        bit   e_iss, e_ack, e_outv;
        int   err_age;

        idle_inputs();
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;

        // ---------- table-driven single-instruction vectors from reset ----------
        add_vec(16'h0000,      5'b11000, 8'h00, 3'b000, 8'h01, 1'b0, 8'h00);
        add_vec(j_op(0, 8'h20), 5'b11000, 8'h00, 3'b000, 8'h20, 1'b0, 8'h00);
        add_vec(j_op(1, 8'h20), 5'b11000, 8'h00, 3'b000, 8'h01, 1'b0, 8'h00);
        add_vec(j_op(2, 8'h20), 5'b11000, 8'h00, 3'b000, 8'h01, 1'b0, 8'h00);
        add_vec(j_op(3, 8'h20), 5'b11000, 8'h00, 3'b000, 8'h20, 1'b0, 8'h00);
        add_vec(j_op(0, 8'h00), 5'b11000, 8'h00, 3'b000, 8'h00, 1'b1, 8'h00);
        add_vec(16'h4000,      5'b11000, 8'h00, 3'b100, 8'h01, 1'b0, 8'h00);
        add_vec(16'h4000,      5'b01000, 8'h00, 3'b100, 8'h00, 1'b0, 8'h00);
        add_vec(16'h7812,      5'b11000, 8'h00, 3'b100, 8'h01, 1'b0, 8'h00);
        add_vec(call_op(8'h33), 5'b11000, 8'h00, 3'b000, 8'h33, 1'b0, 8'h01);
        add_vec(16'hC800,      5'b11000, 8'h00, 3'b000, 8'h00, 1'b0, 8'h00);
        add_vec(16'h2000,      5'b11001, 8'h5A, 3'b100, 8'h01, 1'b0, 8'h5A);
        add_vec(16'hF000,      5'b11100, 8'h00, 3'b010, 8'h01, 1'b0, 8'h00);
        add_vec(16'hF000,      5'b10100, 8'h00, 3'b000, 8'h00, 1'b0, 8'h00);
        add_vec(16'hF000,      5'b11000, 8'h00, 3'b000, 8'h00, 1'b0, 8'h00);
        add_vec(16'hF800,      5'b11010, 8'h00, 3'b001, 8'h01, 1'b0, 8'h00);
        add_vec(16'hF800,      5'b11000, 8'h00, 3'b001, 8'h00, 1'b0, 8'h00);
        add_vec(16'hF800,      5'b10010, 8'h00, 3'b000, 8'h00, 1'b0, 8'h00);
        add_vec(16'h5123,      5'b11000, 8'h00, 3'b000, 8'h00, 1'b1, 8'h00);
        add_vec(16'h8000,      5'b11000, 8'h00, 3'b000, 8'h00, 1'b1, 8'h00);
        add_vec(16'h2F00,      5'b11000, 8'h00, 3'b100, 8'h01, 1'b0, 8'h00);
        add_vec(16'h6F11,      5'b01000, 8'h00, 3'b100, 8'h00, 1'b0, 8'h00);

        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            idle_inputs();
            rom[0] = v.inst;
            do_reset();
            {issue_rdy, dp_idle, bank_in_vld, bank_out_rdy, blink_wr_en} = v.ins;
            blink_wr_data = v.wd;
            #1;
            chk($sformatf("vec%0d issue_vld", i), 32'(issue_vld), 32'(v.eo[2]));
            chk($sformatf("vec%0d bank_in_ack", i), 32'(bank_in_ack), 32'(v.eo[1]));
            chk($sformatf("vec%0d bank_out_vld", i), 32'(bank_out_vld), 32'(v.eo[0]));
            tick();
            chk($sformatf("vec%0d ra", i), 32'(ra), 32'(v.era));
            chk($sformatf("vec%0d err", i), 32'(err), 32'(v.eerr));
            chk($sformatf("vec%0d blink_rd", i), 32'(blink_rd), 32'(v.eblink));
        end

        // ---------- directed program ----------
        idle_inputs();
        for (int a = 0; a < 256; a++) rom[a] = 16'h0000;
        rom[0]    = j_op(0, 8'd96);
        rom[96]   = 16'h6800;
        rom[97]   = j_op(0, 8'd43);
        rom[43]   = 16'h7800;
        rom[44]   = j_op(2, 8'd49);
        rom[49]   = j_op(0, 8'd43);
        rom[45]   = j_op(0, 8'd107);
        rom[107]  = call_op(8'd64);
        rom[64]   = 16'h2F00;
        rom[65]   = 16'hC800;
        rom[108]  = j_op(0, 8'd104);
        rom[104]  = 16'hF000;
        rom[105]  = 16'hF800;
        rom[106]  = j_op(0, 8'hFF);
        rom[255]  = 16'h0000;

        rst = 1'b1;
        tick();
        chk("rst ra", 32'(ra), 0);
        chk("rst issue_vld", 32'(issue_vld), 0);
        chk("rst err", 32'(err), 0);
        chk("rst bank_in_ack", 32'(bank_in_ack), 0);
        chk("rst bank_out_vld", 32'(bank_out_vld), 0);
        chk("rst blink_rd", 32'(blink_rd), 0);
        tick();
        rst = 1'b0;
        chk("release ra", 32'(ra), 0);
        issue_rdy = 1'b0;
        tick();
        chk("jump ra", 32'(ra), 96);
        chk("jump err", 32'(err), 0);

        for (int k = 0; k < 3; k++) begin
            chk("bp ra", 32'(ra), 96);
            chk("bp issue_vld", 32'(issue_vld), 1);
            chk("bp issue_inst", 32'(issue_inst), 32'h6800);
            tick();
        end
        issue_rdy = 1'b1;
        #1 chk("bp issue_vld rdy", 32'(issue_vld), 1);
        tick();
        chk("bp advance ra", 32'(ra), 97);
        tick();
        chk("to sub ra", 32'(ra), 43);

        for (int pass = 0; pass < 2; pass++) begin
            tick();
            for (int k = 0; k < 3; k++) begin
                chk("flag stall ra", 32'(ra), 44);
                chk("flag stall issue", 32'(issue_vld), 0);
                tick();
            end
            flags_vld = 1'b1;
            flags_gt  = (pass == 0);
            flags_eq  = 1'b0;
            chk("flag vld ra", 32'(ra), 44);
            tick();
            flags_vld = 1'b0;
            chk("flag release ra", 32'(ra), 44);
            tick();
            chk(pass == 0 ? "jgt taken ra" : "jgt not taken ra", 32'(ra), pass == 0 ? 49 : 45);
            if (pass == 0) begin
                tick();
                chk("loop back ra", 32'(ra), 43);
            end
        end

        tick();
        chk("to call ra", 32'(ra), 107);
        tick();
        chk("call ra", 32'(ra), 64);
        chk("call blink_rd", 32'(blink_rd), 108);
        tick();
        chk("pop issued ra", 32'(ra), 65);
        tick();
        chk("ret stall ra", 32'(ra), 65);
        blink_wr_en = 1'b1;
        blink_wr_data = 8'h6C;
        chk("ret stall2 ra", 32'(ra), 65);
        tick();
        blink_wr_en = 1'b0;
        chk("ret ra", 32'(ra), 32'h6C);
        chk("ret blink_rd", 32'(blink_rd), 32'h6C);

        tick();
        chk("to await ra", 32'(ra), 104);
        for (int k = 0; k < 5; k++) begin
            chk("await hold ra", 32'(ra), 104);
            chk("await hold ack", 32'(bank_in_ack), 0);
            tick();
        end
        bank_in_vld = 1'b1;
        #1 chk("await ack", 32'(bank_in_ack), 1);
        tick();
        bank_in_vld = 1'b0;
        chk("await done ra", 32'(ra), 105);
        chk("await ack pulse end", 32'(bank_in_ack), 0);

        dp_idle = 1'b0;
        bank_out_rdy = 1'b1;
        #1 chk("emit early rdy vld", 32'(bank_out_vld), 0);
        tick();
        chk("emit early rdy ra", 32'(ra), 105);
        dp_idle = 1'b1;
        bank_out_rdy = 1'b0;
        for (int k = 0; k < 3; k++) begin
            #1 chk("emit hold vld", 32'(bank_out_vld), 1);
            chk("emit hold ra", 32'(ra), 105);
            tick();
        end
        bank_out_rdy = 1'b1;
        #1 chk("emit hs vld", 32'(bank_out_vld), 1);
        tick();
        bank_out_rdy = 1'b0;
        chk("emit done ra", 32'(ra), 106);
        #1 chk("emit vld drop", 32'(bank_out_vld), 0);
        tick();
        chk("to ff ra", 32'(ra), 255);
        tick();
        chk("wrap ra", 32'(ra), 0);

        // ---------- error traps ----------
        idle_inputs();
        rom[0] = 16'h3000;
        do_reset();
        chk("illegal err pre", 32'(err), 0);
        #1 chk("illegal issue", 32'(issue_vld), 0);
        tick();
        bank_in_vld = 1'b1;
        for (int k = 0; k < 3; k++) begin
            chk("illegal err", 32'(err), 1);
            chk("illegal ra frozen", 32'(ra), 0);
            #1 chk("illegal no issue", 32'(issue_vld), 0);
            chk("illegal no ack", 32'(bank_in_ack), 0);
            tick();
        end
        idle_inputs();
        rom[0]   = j_op(0, 8'd128);
        rom[128] = j_op(0, 8'd128);
        do_reset();
        chk("reset clears err", 32'(err), 0);
        tick();
        chk("self jump ra", 32'(ra), 128);
        chk("self jump err pre", 32'(err), 0);
        tick();
        chk("self jump err", 32'(err), 1);
        chk("self jump ra frozen", 32'(ra), 128);

        // ---------- random programs against the model ----------
        for (int p = 0; p < 6; p++) begin
            for (int a = 0; a < 256; a++) rom[a] = rand_inst();
            idle_inputs();
            do_reset();
            model_reset();
            err_age = 0;
            for (int c = 0; c < 400; c++) begin
                issue_rdy     = ($urandom_range(0, 9) < 7);
                dp_idle       = ($urandom_range(0, 9) < 7);
                bank_in_vld   = ($urandom_range(0, 9) < 4);
                bank_out_rdy  = ($urandom_range(0, 1) == 1);
                flags_vld     = m_fp && ($urandom_range(0, 3) == 0);
                flags_eq      = ($urandom_range(0, 1) == 1);
                flags_gt      = ($urandom_range(0, 1) == 1);
                blink_wr_en   = m_bp && ($urandom_range(0, 3) == 0);
                blink_wr_data = 8'($urandom);
                #1;
                chk("rnd ra", 32'(ra), 32'(m_pc));
                chk("rnd err", 32'(err), 32'(m_err));
                chk("rnd blink_rd", 32'(blink_rd), 32'(m_blink));
                chk("rnd issue_inst", 32'(issue_inst), 32'(rom[m_pc[7:0]]));
                model_step(e_iss, e_ack, e_outv);
                chk("rnd issue_vld", 32'(issue_vld), 32'(e_iss));
                chk("rnd bank_in_ack", 32'(bank_in_ack), 32'(e_ack));
                chk("rnd bank_out_vld", 32'(bank_out_vld), 32'(e_outv));
                tick();
                if (m_err) err_age++;
                if (err_age > 3 || $urandom_range(0, 199) == 0) begin
                    idle_inputs();
                    do_reset();
                    model_reset();
                    err_age = 0;
                end
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/qs_srt_ucode_seq.md
Name: qs_srt_ucode_seq

Overview:
- Microcode sequencer for the quicksort engine; it drives the address into the ucode ROM and consumes the returned instruction each cycle.
- Executes control-flow opcodes locally: NOP, Jcc, CALL, RET, WAIT/AWAIT, EMIT.
- Issues every other opcode (PUSH/POP/LD/ST/MOV*/ADD*/SUB*) to the datapath over a valid/ready handshake.
- Owns PC, BLINK and the ALU condition flags, and tracks flag/BLINK hazards against the datapath.

Parameters:
- PC_W, 8, program counter / ROM address width.
- INST_W, 16, instruction width; field positions follow the ucode encoding.
- BLINK_IDX, 7, register index (rrr field) that names BLINK.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- ra  out  PC_W  ROM address; equals the current PC register, no combinational path from rout.
- rout  in  INST_W  ROM instruction at ra, combinational, same cycle.
- issue_vld  out  1  datapath instruction valid.
- issue_inst  out  INST_W  instruction issued to the datapath; equals rout.
- issue_rdy  in  1  datapath accepts the instruction.
- flags_vld  in  1  datapath returns flags for the oldest flag-setting op.
- flags_eq  in  1  result == 0.
- flags_gt  in  1  result > 0.
- blink_wr_en  in  1  datapath writes BLINK (POP BLINK, MOV*/MOVI BLINK).
- blink_wr_data  in  PC_W  BLINK write data.
- blink_rd  out  PC_W  current BLINK, used by PUSH BLINK.
- dp_idle  in  1  datapath has no instruction in flight.
- bank_in_vld  in  1  input bank holds unsorted data.
- bank_in_ack  out  1  one-cycle pulse: AWAIT consumed.
- bank_out_vld  out  1  EMIT request: sorted bank complete.
- bank_out_rdy  in  1  downstream accepts the EMIT.
- err  out  1  sticky error indication.

Behaviour:
- Reset, synchronous: PC=0, BLINK=0, flag_eq=0, flag_gt=0, flags_pend=0, blink_pend=0, state=RUN, err=0. All outputs are 0 during and after reset, except ra=0. A reset mid-operation abandons all state, including a held EMIT or AWAIT.
- Decode on rout[15:12]:
  - 0000 NOP, 0001 Jcc, 0010 PUSH/POP, 0100 LD/ST, 0110 MOV*, 0111 ADD/SUB, 1100 CALL/RET, 1111 AWAIT/EMIT.
  - Any other opcode is illegal: go to ERR.
- PC advance is always PC+1 modulo 2^PC_W; 0xFF wraps to 0x00.
- States: RUN, ERR. AWAIT and EMIT stall in RUN via the hold conditions below; there are no extra states.
- NOP: PC+1, 1 cycle.
- Datapath op:
  - issue_vld=1 while in RUN, no hazard stall and the op is non-control.
  - PC advances only on issue_vld&&issue_rdy; issue_inst holds stable while stalled.
- flags_pend:
  - Set on issue of a SUB/SUBI (0111_1...).
  - Cleared on flags_vld, which also loads flag_eq/flag_gt.
  - Issue and flags_vld in the same cycle: set wins.
  - A further SUB issue while flags_pend=1 stalls until clear, so at most one flag op is outstanding.
- blink_pend:
  - Set on issue of POP (0010_1), MOV/MOVI/MOVS (0110) whose rrr==BLINK_IDX.
  - Cleared on blink_wr_en.
  - blink_wr_en also updates BLINK.
- Jcc, cc=rout[9:8]:
  - 00 is unconditional.
  - For 01/10/11, the instruction stalls while flags_pend=1.
  - Conditions: 01 taken if flag_eq; 10 taken if flag_gt; 11 taken if !flag_gt.
  - Taken: PC<=rout[7:0]; otherwise PC+1.
  - Unconditional J whose target equals PC: enter ERR (error trap).
- CALL: BLINK<=PC+1 and PC<=rout[7:0] in one cycle. It stalls while blink_pend=1, so a pending write cannot be lost.
- RET:
  - Stalls while blink_pend=1; otherwise PC<=BLINK.
  - blink_wr_en in the same cycle as a RET stall release: RET uses the newly written value, not the stale one.
- AWAIT (1111_0): holds PC while bank_in_vld=0 or dp_idle=0. When both are 1: bank_in_ack=1 for one cycle and PC+1.
- EMIT (1111_1):
  - Waits for dp_idle=1 and flags_pend=0 and blink_pend=0, then asserts bank_out_vld.
  - bank_out_vld holds until bank_out_rdy; on the handshake cycle PC+1 and bank_out_vld drops next cycle.
  - bank_out_rdy high before bank_out_vld is ignored.
- ERR: err=1 and PC frozen; no issue, ack or emit. Only rst exits.
- Latency: a control op retires in 1 cycle absent stalls; a taken branch has zero bubbles, because the ROM is combinational.

Test Plan:
- Reset: rst for 2 cycles, ROM[0]=J 96 -> ra=0 during reset, ra=96 on the second cycle after release, err=0.
- Issue backpressure: ROM[96]=MOVI R0,0, issue_rdy low for 3 cycles -> ra stays 96 and issue_inst stable for 3 cycles; ra=97 on the cycle after issue_rdy=1.
- Flag hazard: SUB.F at 43, JGT 49 at 44, flags_vld 4 cycles after issue with gt=1 -> ra held at 44 until flags_vld, then ra=49. Repeat with gt=0 -> ra=45.
- CALL/RET with BLINK hazard: CALL 64 at 107 -> ra=64, blink_rd=108. Issue POP BLINK then RET; blink_wr_data=0x6C arrives 2 cycles later -> RET stalls, then ra=0x6C.
- AWAIT/EMIT: AWAIT at 104 with bank_in_vld=0 for 5 cycles -> ra=104 and bank_in_ack=0; on bank_in_vld=1 -> single ack pulse. EMIT with bank_out_rdy delayed 3 cycles -> bank_out_vld held 3 cycles, PC+1 on handshake.
- Error and wrap: rout=0x3000 -> err=1 next cycle, no further issue until rst. J 128 at 128 -> err=1. NOP at PC=0xFF -> ra=0x00.
